// File: rtl/range_pkg.sv
// Shared types and defaults for the ranging sequencer.
// State encoding is kept here so the bench and any wrappers agree on it.
package range_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BURST  = 3'd1,
    ST_GUARD  = 3'd2,
    ST_LISTEN = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int GUARD_TICKS_DEFAULT = 4;

  function automatic logic is_busy(input state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Programmable tick divider: counts 0..div and pulses tick when count==div.
// restart forces the count back to 0 so every phase begins with a full period.
module tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (restart || (count_reg == div)) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + DIV_W'(1);
    end
  end

  assign tick = (count_reg == div);

endmodule

// File: rtl/range_seq.sv
// Ultrasonic-style ranging sequencer: tx burst, guard interval, then listen
// for an echo edge while counting ticks until echo or timeout.
module range_seq
  import range_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int CNT_W       = 16,
  parameter int GUARD_TICKS = GUARD_TICKS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] burst_div,
  input  logic [7:0]       burst_len,
  input  logic [DIV_W-1:0] listen_div,
  input  logic [CNT_W-1:0] timeout,
  input  logic             echo,
  output logic             tx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] range,
  output logic             hit,
  output logic             timed_out
);

  localparam int GW = (GUARD_TICKS > 1) ? $clog2(GUARD_TICKS) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_TICKS - 1);

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] bdiv_reg, bdiv_next;
  logic [7:0]       blen_reg, blen_next;
  logic [DIV_W-1:0] ldiv_reg, ldiv_next;
  logic [CNT_W-1:0] tmo_reg, tmo_next;
  logic [7:0]       pulse_reg, pulse_next;
  logic [GW-1:0]    guard_reg, guard_next;
  logic [CNT_W-1:0] range_reg, range_next;
  logic             hit_reg, hit_next;
  logic             to_reg, to_next;
  logic             echo_prev_reg;

  logic             tick;
  logic             restart;
  logic [DIV_W-1:0] tick_div;
  logic             echo_edge;

  assign tick_div  = (state_reg == ST_BURST) ? bdiv_reg : ldiv_reg;
  // Idle holds the divider at zero; any state change restarts the period.
  assign restart   = (state_reg == ST_IDLE) || (state_next != state_reg);
  assign echo_edge = echo & ~echo_prev_reg;

  tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .div    (tick_div),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      bdiv_reg      <= '0;
      blen_reg      <= '0;
      ldiv_reg      <= '0;
      tmo_reg       <= '0;
      pulse_reg     <= '0;
      guard_reg     <= '0;
      range_reg     <= '0;
      hit_reg       <= 1'b0;
      to_reg        <= 1'b0;
      echo_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bdiv_reg      <= bdiv_next;
      blen_reg      <= blen_next;
      ldiv_reg      <= ldiv_next;
      tmo_reg       <= tmo_next;
      pulse_reg     <= pulse_next;
      guard_reg     <= guard_next;
      range_reg     <= range_next;
      hit_reg       <= hit_next;
      to_reg        <= to_next;
      echo_prev_reg <= echo;
    end
  end

  always_comb begin
    state_next = state_reg;
    bdiv_next  = bdiv_reg;
    blen_next  = blen_reg;
    ldiv_next  = ldiv_reg;
    tmo_next   = tmo_reg;
    pulse_next = pulse_reg;
    guard_next = guard_reg;
    range_next = range_reg;
    hit_next   = hit_reg;
    to_next    = to_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          bdiv_next  = burst_div;
          blen_next  = burst_len;
          ldiv_next  = listen_div;
          tmo_next   = timeout;
          pulse_next = '0;
          guard_next = '0;
          range_next = '0;
          hit_next   = 1'b0;
          to_next    = 1'b0;
          state_next = (burst_len == 8'd0) ? ST_GUARD : ST_BURST;
        end
      end
      ST_BURST: begin
        if (tick) begin
          if (pulse_reg == blen_reg - 8'd1) begin
            state_next = ST_GUARD;
          end else begin
            pulse_next = pulse_reg + 8'd1;
          end
        end
      end
      ST_GUARD: begin
        if (tick) begin
          if (guard_reg == GUARD_LAST) begin
            state_next = ST_LISTEN;
          end else begin
            guard_next = guard_reg + GW'(1);
          end
        end
      end
      ST_LISTEN: begin
        // Echo takes priority over a coincident timeout tick.
        if (echo_edge) begin
          hit_next   = 1'b1;
          state_next = ST_DONE;
        end else if (tick) begin
          if (range_reg == tmo_reg) begin
            to_next    = 1'b1;
            state_next = ST_DONE;
          end else begin
            range_next = range_reg + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (abort && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      range_next = range_reg;
      hit_next   = 1'b0;
      to_next    = 1'b0;
    end
  end

  assign tx        = (state_reg == ST_BURST) && tick;
  assign busy      = is_busy(state_reg);
  assign done      = (state_reg == ST_DONE);
  assign range     = range_reg;
  assign hit       = hit_reg;
  assign timed_out = to_reg;

endmodule

// File: doc/range_seq.md
RANGE_SEQ -- requirements
Module: range_seq

Interface
REQ-001 The block SHALL have parameter DIV_W, default 8, meaning the width of the divider inputs and of the tick counter.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of timeout and range.
REQ-003 The block SHALL have parameter GUARD_TICKS, default 4, meaning the number of listen ticks during which echo is ignored after the burst.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle request to begin a measurement.
REQ-007 abort  in  1  synchronous cancel of a running measurement.
REQ-008 burst_div  in  DIV_W  tick divider for the burst phase.
REQ-009 burst_len  in  8  number of tx pulses per burst.
REQ-010 listen_div  in  DIV_W  tick divider for the guard and listen phases.
REQ-011 timeout  in  CNT_W  maximum listen ticks.
REQ-012 echo  in  1  echo detector output, already synchronous to clk.
REQ-013 tx  out  1  one-cycle transmit pulse.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 range  out  CNT_W  listen-tick count captured at echo or timeout.
REQ-017 hit  out  1  the last measurement ended on an echo.
REQ-018 timed_out  out  1  the last measurement ended on a timeout.

Function
REQ-019 The FSM SHALL have states IDLE, BURST, GUARD, LISTEN and DONE.
REQ-020 In IDLE, start=1 SHALL latch burst_div, burst_len, listen_div and timeout, clear hit, timed_out and range, and enter BURST on the next edge.
REQ-021 If the latched burst_len is 0, IDLE SHALL enter GUARD directly and SHALL emit no tx pulse.
REQ-022 start SHALL be ignored in every state other than IDLE.
REQ-023 The tick generator SHALL count 0..div and assert tick when count==div (period div+1 cycles).
REQ-024 The tick counter SHALL restart at 0 on every state entry, including the change of divider between BURST and GUARD.
REQ-025 In BURST, tx SHALL equal tick, and a pulse counter SHALL increment on each tick.
REQ-026 On the burst_len-th tx pulse, the FSM SHALL enter GUARD on the same edge.
REQ-027 In GUARD, echo SHALL be ignored and the FSM SHALL enter LISTEN after GUARD_TICKS listen ticks.
REQ-028 In LISTEN, range SHALL increment on each tick, saturating at timeout.
REQ-029 An echo rising edge in LISTEN (echo=1 with previous-cycle echo=0) SHALL set hit=1, freeze range, and enter DONE.
REQ-030 When range==timeout and a tick occurs, the FSM SHALL set timed_out=1 and enter DONE.
REQ-031 If an echo edge and a timeout tick occur in the same cycle, the echo SHALL win.
REQ-032 The echo-edge register SHALL be updated every cycle, so that an echo already high on entry to LISTEN is not an edge.
REQ-033 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-034 range, hit and timed_out SHALL hold their values until the next accepted start.
REQ-035 abort in any non-IDLE state SHALL return the FSM to IDLE on the next edge, with done=0, tx=0, hit=0 and timed_out=0, leaving range as counted.
REQ-036 timeout=0 SHALL end the measurement on the first listen tick in LISTEN with range=0.

Reset
REQ-037 While reset=0, the block SHALL hold the state IDLE and tx=0, busy=0, done=0, range=0, hit=0, timed_out=0, with all counters and latched configuration at 0.
REQ-038 Assertion of reset mid-operation SHALL take effect immediately (asynchronously) and SHALL produce no done pulse.

Structure
REQ-039 The state encoding and the GUARD_TICKS default SHALL live in the shared package range_pkg.
REQ-040 The tick divider SHALL be a sub-module tick_gen (inputs: clk, reset, restart, div; output: tick).

Verification
REQ-041 burst_div=3, burst_len=4 -> four tx pulses 4 cycles apart, then GUARD.
REQ-042 listen_div=1, timeout=100, echo rises after 10 listen ticks in LISTEN -> range=10, hit=1, done pulses once.
REQ-043 No echo, timeout=5 -> timed_out=1, range=5, hit=0.
REQ-044 Echo high throughout GUARD and held through LISTEN -> no hit; ends in timeout.
REQ-045 abort in LISTEN, and separately reset=0 in BURST -> IDLE, no done, tx=0; next start runs normally.
REQ-046 burst_len=0, and separately start pulsed while busy -> no tx; the second start is ignored.
